// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-input, one-output registered selector with valid/ready
// handshakes on every channel. It works as an explicit select or as a round-robin arbiter.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_data     flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid    per-channel request
//   in_ready    per-channel accept (combinational)
//   sel         channel index, used only when RR_MODE=0
//   out_data    registered selected data
//   out_valid   out_data holds an unconsumed beat
//   out_ready   downstream accept
//   out_src     index of the channel that supplied out_data
module mux_arb_nto1 #(
    parameter int WIDTH   = 32,
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = $clog2(NUM_IN),
    parameter bit RR_MODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic              load_en;
    logic              armed;
    logic              xfer;
    logic              found;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  idx;
    logic [SEL_W-1:0]  gidx;

    // Grant vector: one-hot or zero. Round-robin starts one past ptr.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (RR_MODE) begin
            for (int k = 1; k <= NUM_IN; k++) begin
                idx = SEL_W'((int'(ptr) + k) % NUM_IN);
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end else begin
            // An out-of-range sel matches no channel and grants nothing.
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i)) begin
                    grant[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                gidx = SEL_W'(i);
            end
        end
    end

    assign load_en = !out_valid || out_ready;

    // armed keeps in_ready low until the first edge after reset release.
    assign in_ready = (armed && load_en) ? grant : '0;
    assign xfer     = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SEL_W'(NUM_IN - 1);
        end else begin
            armed <= 1'b1;
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= in_data[gidx*WIDTH +: WIDTH];
                    out_src  <= gidx;
                end
            end
            if (xfer) begin
                ptr <= gidx;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: directed bench for mux_arb_nto1 covering explicit select,
// out-of-range select, backpressure, round-robin rotation and reset.
module tb_mux_arb_nto1;

    logic clk;
    logic rst_n;

    // dut0: explicit select, NUM_IN=4
    logic [127:0] in_data0;
    logic [3:0]   in_valid0, in_ready0;
    logic [1:0]   sel0, out_src0;
    logic [31:0]  out_data0;
    logic         out_valid0, out_ready0;

    // dut1: explicit select, NUM_IN=3
    logic [95:0]  in_data1;
    logic [2:0]   in_valid1, in_ready1;
    logic [1:0]   sel1, out_src1;
    logic [31:0]  out_data1;
    logic         out_valid1, out_ready1;

    // dut2: round-robin, NUM_IN=4
    logic [127:0] in_data2;
    logic [3:0]   in_valid2, in_ready2;
    logic [1:0]   sel2, out_src2;
    logic [31:0]  out_data2;
    logic         out_valid2, out_ready2;

    int n_chk;
    int n_fail;

    mux_arb_nto1 #(.WIDTH(32), .NUM_IN(4), .RR_MODE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .sel(sel0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_src(out_src0)
    );

    mux_arb_nto1 #(.WIDTH(32), .NUM_IN(3), .RR_MODE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .sel(sel1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_src(out_src1)
    );

    mux_arb_nto1 #(.WIDTH(32), .NUM_IN(4), .RR_MODE(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .sel(sel2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_src(out_src2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] exp_d [4];
        int          gseq [10];
        exp_d = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
        gseq  = '{0, 1, 2, 3, 0, 1, 2, 0, 2, 0};
        n_chk  = 0;
        n_fail = 0;

        rst_n = 1'b1;
        in_data0 = '0; in_valid0 = '0; sel0 = '0; out_ready0 = 1'b0;
        in_data1 = '0; in_valid1 = '0; sel1 = '0; out_ready1 = 1'b0;
        in_data2 = '0; in_valid2 = '0; sel2 = '0; out_ready2 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid0), 32'd0);
        chk("rst_data", out_data0, 32'd0);
        chk("rst_src", 32'(out_src0), 32'd0);

        in_data0   = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
        in_valid0  = 4'b1111;
        out_ready0 = 1'b1;
        sel0       = 2'd0;
        #1;
        chk("rst_rdy_low", 32'(in_ready0), 32'd0);
        #9 rst_n = 1'b1;
        #1;
        chk("rel_rdy_low", 32'(in_ready0), 32'd0);
        tick();

        // Explicit select stepping 0..3, one beat per cycle
        for (int s = 0; s < 4; s++) begin
            sel0 = 2'(s);
            #1;
            chk("sel_rdy", 32'(in_ready0), 32'(1 << s));
            tick();
            chk("sel_data", out_data0, exp_d[s]);
            chk("sel_src", 32'(out_src0), 32'(s));
            chk("sel_valid", 32'(out_valid0), 32'd1);
        end

        // Backpressure with 0xB1 held
        sel0 = 2'd1;
        #1;
        tick();
        chk("bp_load", out_data0, 32'hB1);
        out_ready0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sel0     = 2'(c % 4);
            in_data0 = {4{32'hE0 + 32'(c)}};
            #1;
            chk("bp_rdy", 32'(in_ready0), 32'd0);
            tick();
            chk("bp_data", out_data0, 32'hB1);
            chk("bp_src", 32'(out_src0), 32'd1);
            chk("bp_valid", 32'(out_valid0), 32'd1);
        end
        in_data0   = {32'h5D3, 32'h5C2, 32'h5B1, 32'h5A0};
        sel0       = 2'd2;
        out_ready0 = 1'b1;
        #1;
        chk("dl_rdy", 32'(in_ready0), 32'h4);
        tick();
        chk("dl_data", out_data0, 32'h5C2);
        chk("dl_src", 32'(out_src0), 32'd2);
        chk("dl_valid", 32'(out_valid0), 32'd1);
        in_valid0 = 4'b0000;
        #1;
        tick();
        chk("idle_valid", 32'(out_valid0), 32'd0);
        chk("idle_data", out_data0, 32'h5C2);

        // Out-of-range select on a 3-channel instance
        in_data1   = {32'h33, 32'h22, 32'h11};
        in_valid1  = 3'b111;
        out_ready1 = 1'b1;
        sel1       = 2'd1;
        #1;
        chk("oor_pre_rdy", 32'(in_ready1), 32'h2);
        tick();
        chk("oor_pre_data", out_data1, 32'h22);
        sel1 = 2'd3;
        #1;
        chk("oor_rdy", 32'(in_ready1), 32'd0);
        tick();
        chk("oor_valid", 32'(out_valid1), 32'd0);
        chk("oor_data", out_data1, 32'h22);
        chk("oor_src", 32'(out_src1), 32'd1);

        // Round-robin rotation then sparse requests
        in_data2   = {32'h103, 32'h102, 32'h101, 32'h100};
        in_valid2  = 4'b1111;
        out_ready2 = 1'b1;
        sel2       = 2'd3;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) in_valid2 = 4'b0101;
            #1;
            chk("rr_rdy", 32'(in_ready2), 32'(1 << gseq[k]));
            tick();
            chk("rr_src", 32'(out_src2), 32'(gseq[k]));
            chk("rr_data", out_data2, 32'h100 + 32'(gseq[k]));
        end
        in_valid2 = 4'b1111;
        #1;
        tick();
        chk("rr_g1", 32'(out_src2), 32'd1);

        // Stall with ptr=1
        out_ready2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rrs_rdy", 32'(in_ready2), 32'd0);
            tick();
            chk("rrs_src", 32'(out_src2), 32'd1);
            chk("rrs_valid", 32'(out_valid2), 32'd1);
        end
        out_ready2 = 1'b1;
        #1;
        chk("rrs_rel_rdy", 32'(in_ready2), 32'h4);
        tick();
        chk("rrs_rel_src", 32'(out_src2), 32'd2);
        chk("rrs_rel_data", out_data2, 32'h102);

        // Reset mid-stream with a held beat
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid2), 32'd0);
        chk("mrst_data", out_data2, 32'd0);
        chk("mrst_src", 32'(out_src2), 32'd0);
        chk("mrst_rdy", 32'(in_ready2), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        #1;
        chk("mrel_rdy", 32'(in_ready2), 32'd0);
        tick();
        chk("mrel_rdy1", 32'(in_ready2), 32'h1);
        tick();
        chk("mrel_src", 32'(out_src2), 32'd0);
        chk("mrel_data", out_data2, 32'h100);
        chk("mrel_valid", 32'(out_valid2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
